// File: rtl/chip8_sprite_drawer.sv
// CHIP-8/XO-CHIP sprite blitter: reads sprite rows from RAM and XORs them into a 2-plane VRAM.
// Latency 1+18*N cycles from accepted start to done; start is ignored unless IDLE.
module chip8_sprite_drawer (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [6:0]  x,
    input  logic [5:0]  y,
    input  logic [3:0]  rows,
    input  logic [11:0] sprite_addr,
    input  logic [1:0]  plane,
    output logic        busy,
    output logic        done,
    output logic        collision,
    output logic [11:0] ram_addr,
    input  logic [7:0]  ram_dout,
    output logic [6:0]  vram_hpos,
    output logic [5:0]  vram_vpos,
    output logic [1:0]  vram_pixeli,
    input  logic [1:0]  vram_pixelo,
    output logic        vram_we
);

    typedef enum logic [2:0] {
        IDLE,
        ROW_ADDR,
        ROW_DATA,
        PIX_RD,
        PIX_WR,
        DONE
    } state_t;

    state_t      state;
    logic [6:0]  x_l;
    logic [5:0]  y_l;
    logic [3:0]  rows_m1;
    logic [11:0] addr_l;
    logic [1:0]  plane_l;
    logic [3:0]  row;
    logic [2:0]  col;
    logic [7:0]  shreg;

    // Extra carry bit on the sums detects pixels falling off the right/bottom edge.
    logic [7:0]  col_sum;
    logic [6:0]  row_sum;
    logic        pix_en;
    logic [2:0]  col_nxt;
    logic [3:0]  row_nxt;
    logic [6:0]  hpos_nxt;
    logic [11:0] addr_nxt;

    assign col_sum  = {1'b0, x_l} + {5'b0, col};
    assign row_sum  = {1'b0, y_l} + {3'b0, row};
    assign pix_en   = shreg[7] && (plane_l != 2'b00) && !col_sum[7] && !row_sum[6];
    assign col_nxt  = col + 3'd1;
    assign row_nxt  = row + 4'd1;
    assign hpos_nxt = x_l + {4'b0, col_nxt};
    assign addr_nxt = addr_l + {8'b0, row_nxt};

    // Write data must follow the VRAM read that lands in the PIX_WR cycle itself.
    assign vram_pixeli = vram_we ? (vram_pixelo ^ plane_l) : 2'b00;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            collision <= 1'b0;
            ram_addr  <= 12'd0;
            vram_hpos <= 7'd0;
            vram_vpos <= 6'd0;
            vram_we   <= 1'b0;
            x_l       <= 7'd0;
            y_l       <= 6'd0;
            rows_m1   <= 4'd0;
            addr_l    <= 12'd0;
            plane_l   <= 2'b00;
            row       <= 4'd0;
            col       <= 3'd0;
            shreg     <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        x_l       <= x;
                        y_l       <= y;
                        rows_m1   <= rows - 4'd1;
                        addr_l    <= sprite_addr;
                        plane_l   <= plane;
                        row       <= 4'd0;
                        collision <= 1'b0;
                        ram_addr  <= sprite_addr;
                        busy      <= 1'b1;
                        state     <= ROW_ADDR;
                    end
                end
                ROW_ADDR: state <= ROW_DATA;
                ROW_DATA: begin
                    shreg     <= ram_dout;
                    col       <= 3'd0;
                    vram_hpos <= x_l;
                    vram_vpos <= row_sum[5:0];
                    state     <= PIX_RD;
                end
                PIX_RD: begin
                    vram_we <= pix_en;
                    state   <= PIX_WR;
                end
                PIX_WR: begin
                    vram_we <= 1'b0;
                    if (vram_we && ((vram_pixelo & plane_l) != 2'b00))
                        collision <= 1'b1;
                    if (col == 3'd7) begin
                        if (row == rows_m1) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            row      <= row_nxt;
                            ram_addr <= addr_nxt;
                            state    <= ROW_ADDR;
                        end
                    end else begin
                        col       <= col_nxt;
                        shreg     <= {shreg[6:0], 1'b0};
                        vram_hpos <= hpos_nxt;
                        state     <= PIX_RD;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    vram_we <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_chip8_sprite_drawer.sv
// Directed vector bench for chip8_sprite_drawer with behavioural sync RAM and VRAM.
module tb_chip8_sprite_drawer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [6:0]  x;
    logic [5:0]  y;
    logic [3:0]  rows;
    logic [11:0] sprite_addr;
    logic [1:0]  plane;
    logic        busy, done, collision;
    logic [11:0] ram_addr;
    logic [7:0]  ram_dout;
    logic [6:0]  vram_hpos;
    logic [5:0]  vram_vpos;
    logic [1:0]  vram_pixeli;
    logic [1:0]  vram_pixelo;
    logic        vram_we;

    chip8_sprite_drawer dut (
        .clk(clk), .rst(rst), .start(start), .x(x), .y(y), .rows(rows),
        .sprite_addr(sprite_addr), .plane(plane), .busy(busy), .done(done),
        .collision(collision), .ram_addr(ram_addr), .ram_dout(ram_dout),
        .vram_hpos(vram_hpos), .vram_vpos(vram_vpos), .vram_pixeli(vram_pixeli),
        .vram_pixelo(vram_pixelo), .vram_we(vram_we)
    );

    always #5 clk = ~clk;

    logic [7:0] ram [0:4095];
    logic [1:0] vram [0:63][0:127];
    int wr_count = 0;
    int proto_err = 0;
    logic prev_we = 1'b0;

    always @(posedge clk) begin
        ram_dout    <= ram[ram_addr];
        vram_pixelo <= vram[vram_vpos][vram_hpos];
        if (vram_we) begin
            vram[vram_vpos][vram_hpos] <= vram_pixeli;
            wr_count++;
            if (prev_we || !busy) proto_err++;
        end
        prev_we <= vram_we;
    end

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    typedef struct {
        int x, y, rows, addr, plane;
        int lat, nwr, coll;
        int p1h, p1v, p1val, p2h, p2v, p2val;
        bit bstart;
    } vec_t;

    vec_t tv [7];

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_coll"}, collision, 0);
        chk({tag, "_we"}, vram_we, 0);
        chk({tag, "_ram_addr"}, ram_addr, 0);
        chk({tag, "_hpos"}, vram_hpos, 0);
        chk({tag, "_vpos"}, vram_vpos, 0);
        chk({tag, "_pixeli"}, vram_pixeli, 0);
    endtask

    task automatic run_draw(input int i);
        vec_t v;
        int cyc, wr0, nrows;
        bit addr_ok;
        v = tv[i];
        nrows = (v.rows == 0) ? 16 : v.rows;
        addr_ok = 1'b1;
        @(negedge clk);
        x = 7'(v.x); y = 6'(v.y); rows = 4'(v.rows);
        sprite_addr = 12'(v.addr); plane = 2'(v.plane);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = v.bstart;
        x = 7'($urandom); y = 6'($urandom); rows = 4'($urandom);
        sprite_addr = 12'($urandom); plane = 2'($urandom);
        wr0 = wr_count;
        cyc = 1;
        while (cyc < 400) begin
            if ((cyc - 1) % 18 == 0 && (cyc - 1) / 18 < nrows)
                if (ram_addr !== 12'(v.addr + (cyc - 1) / 18)) addr_ok = 1'b0;
            if (done) break;
            @(posedge clk);
            #1;
            cyc++;
        end
        chk($sformatf("v%0d_latency", i), cyc, v.lat);
        chk($sformatf("v%0d_busy_in_done", i), busy, 0);
        // start may still be high here, which spans the DONE-cycle edge.
        @(posedge clk);
        #1;
        start = 1'b0;
        chk($sformatf("v%0d_done_one_cycle", i), done, 0);
        chk($sformatf("v%0d_no_restart", i), busy, 0);
        chk($sformatf("v%0d_ram_addrs", i), addr_ok, 1);
        chk($sformatf("v%0d_writes", i), wr_count - wr0, v.nwr);
        chk($sformatf("v%0d_collision", i), collision, v.coll);
        chk($sformatf("v%0d_pix1", i), vram[v.p1v][v.p1h], v.p1val);
        chk($sformatf("v%0d_pix2", i), vram[v.p2v][v.p2h], v.p2val);
    endtask

    initial begin
        int cyc, wsnap;
        bit done_seen;
        for (int a = 0; a < 4096; a++) ram[a] = 8'h00;
        for (int r = 0; r < 64; r++)
            for (int c = 0; c < 128; c++) vram[r][c] = 2'b00;
        ram[12'h200] = 8'hF0;
        ram[12'h400] = 8'hFF; ram[12'h401] = 8'hFF;
        ram[12'h500] = 8'h80;
        ram[12'hFFF] = 8'h80; ram[12'h000] = 8'h40;
        for (int a = 12'h600; a < 12'h604; a++) ram[a] = 8'hFF;

        //          x    y   rows addr   pl  lat  nwr coll p1h p1v p1 p2h p2v p2 bstart
        tv[0] = '{10,  5,  1, 'h200, 1,  19,  4, 0,  13,  5, 1, 14,  5, 0, 1'b0};
        tv[1] = '{10,  5,  1, 'h200, 1,  19,  4, 1,  10,  5, 0, 13,  5, 0, 1'b0};
        tv[2] = '{ 0,  0,  0, 'h300, 1, 289,  0, 0,   0,  0, 0,  7, 15, 0, 1'b0};
        tv[3] = '{124, 63, 2, 'h400, 3,  37,  4, 0, 127, 63, 3,124,  0, 0, 1'b0};
        tv[4] = '{20, 10,  1, 'h500, 2,  19,  1, 0,  20, 10, 3, 21, 10, 0, 1'b0};
        tv[5] = '{40, 40,  2, 'hFFF, 1,  37,  2, 0,  40, 40, 1, 41, 41, 1, 1'b0};
        tv[6] = '{60, 20,  1, 'h200, 0,  19,  0, 0,  60, 20, 0, 61, 20, 0, 1'b1};

        rst = 1'b1; start = 1'b1; x = '0; y = '0; rows = '0; sprite_addr = '0; plane = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0; start = 1'b0;

        for (int i = 0; i < 7; i++) begin
            if (i == 4) vram[10][20] = 2'b01;
            run_draw(i);
        end

        // Abort a 4-row draw with reset in cycle T+10.
        @(negedge clk);
        x = 7'd0; y = 6'd30; rows = 4'd4; sprite_addr = 12'h600; plane = 2'b01;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 1;
        while (cyc < 10) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("abort_busy_before", busy, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_outputs("abort");
        wsnap = wr_count;
        done_seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) done_seen = 1'b1;
        end
        chk("abort_no_done", done_seen, 0);
        chk("abort_no_writes", wr_count - wsnap, 0);
        chk("abort_vram_partial", vram[30][0], 1);

        run_draw(0);
        chk("protocol_we", proto_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
